ram_sync_be: RTL and testbench

- Parametrised single-port synchronous RAM. Successor to the 32-bit register-style store.
- Adds true addressable depth, a registered read with a valid strobe, and per-byte write enables.
- Adds a selectable write-through mode and a hardware clear sequencer that zeroes the array after reset or on request.
- Sits on the processor data bus as general-purpose data/scratch memory behind chip_select decoding.

---
 rtl/ram_sync_be.sv | 134 +++++++++++++
 tb/tb_ram_sync_be.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync_be.sv
// Single-port synchronous RAM with byte enables, a registered read and valid strobe,
// optional write-through, and a sequencer that zeroes the array after reset or on request.
module ram_sync_be #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned DEPTH         = 32,
  parameter int unsigned WRITE_THROUGH = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    chip_select,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    clear,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    read_valid,
  output logic                    busy
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if ((DATA_WIDTH % 8) != 0 || DEPTH < 1 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_params
    $error("ram_sync_be: illegal DATA_WIDTH/DEPTH/ADDR_WIDTH combination");
  end

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      clear_ptr_q, clear_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  read_valid_q, read_valid_d;
  logic                  busy_q, busy_d;

  logic                  in_range_c;
  logic [PTR_W-1:0]      idx_c;
  logic                  access_c;
  logic                  wr_c;
  logic [DATA_WIDTH-1:0] rd_word_c;
  logic [DATA_WIDTH-1:0] merged_c;

  // A pending clear wins over an access presented in the same cycle.
  assign in_range_c = (32'(address) < DEPTH);
  assign idx_c      = address[PTR_W-1:0];
  assign access_c   = (state_q == ST_IDLE) && !clear && chip_select;
  assign wr_c       = access_c && we && in_range_c;
  assign rd_word_c  = in_range_c ? mem[idx_c] : '0;

  always_comb begin
    merged_c = rd_word_c;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (byte_en[i]) merged_c[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  // Array has no reset; the clear sequencer owns it while busy.
  always_ff @(posedge clock) begin
    if (state_q == ST_CLEAR) begin
      mem[clear_ptr_q] <= '0;
    end else if (wr_c) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (byte_en[i]) mem[idx_c][8*i +: 8] <= data_in[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    clear_ptr_d  = clear_ptr_q;
    data_out_d   = data_out_q;
    read_valid_d = 1'b0;
    busy_d       = busy_q;
    case (state_q)
      ST_CLEAR: begin
        busy_d = 1'b1;
        if (clear_ptr_q == PTR_W'(DEPTH - 1)) begin
          state_d     = ST_IDLE;
          clear_ptr_d = '0;
          busy_d      = 1'b0;
        end else begin
          clear_ptr_d = clear_ptr_q + PTR_W'(1);
        end
      end
      ST_IDLE: begin
        busy_d = 1'b0;
        if (clear) begin
          state_d     = ST_CLEAR;
          clear_ptr_d = '0;
          busy_d      = 1'b1;
        end else if (access_c) begin
          if (!we) begin
            data_out_d   = rd_word_c;
            read_valid_d = 1'b1;
          end else if (WRITE_THROUGH != 0 && in_range_c) begin
            data_out_d = merged_c;
          end
        end
      end
      default: begin
        state_d     = ST_CLEAR;
        clear_ptr_d = '0;
        busy_d      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_CLEAR;
      clear_ptr_q  <= '0;
      data_out_q   <= '0;
      read_valid_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      clear_ptr_q  <= clear_ptr_d;
      data_out_q   <= data_out_d;
      read_valid_q <= read_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign read_valid = read_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ram_sync_be.sv
// Directed bench for ram_sync_be: default, write-through and DEPTH=20 instances share stimulus;
// reads on the default instance are scoreboarded through an expected-data queue.
module tb_ram_sync_be;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        chip_select, we, clear;
  logic [3:0]  byte_en;
  logic [4:0]  address;
  logic [31:0] data_in;

  logic [31:0] dout_m, dout_w, dout_d;
  logic        rv_m, rv_w, rv_d;
  logic        busy_m, busy_w, busy_d;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  ram_sync_be u_main (
    .clock(clock), .reset_n(reset_n), .chip_select(chip_select), .we(we), .byte_en(byte_en),
    .address(address), .data_in(data_in), .clear(clear),
    .data_out(dout_m), .read_valid(rv_m), .busy(busy_m));

  ram_sync_be #(.WRITE_THROUGH(1)) u_wt (
    .clock(clock), .reset_n(reset_n), .chip_select(chip_select), .we(we), .byte_en(byte_en),
    .address(address), .data_in(data_in), .clear(clear),
    .data_out(dout_w), .read_valid(rv_w), .busy(busy_w));

  ram_sync_be #(.DEPTH(20)) u_d20 (
    .clock(clock), .reset_n(reset_n), .chip_select(chip_select), .we(we), .byte_en(byte_en),
    .address(address), .data_in(data_in), .clear(clear),
    .data_out(dout_d), .read_valid(rv_d), .busy(busy_d));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then compare the default instance against the scoreboard.
  task automatic tick();
    logic [31:0] e;
    @(posedge clock);
    #1;
    check("main_read_valid", 32'(rv_m), 32'(exp_q.size() > 0));
    if (rv_m === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("main_read_data", dout_m, e);
    end
  endtask

  task automatic set_idle();
    chip_select = 1'b0; we = 1'b0; clear = 1'b0; byte_en = 4'h0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    chip_select = 1'b1; we = 1'b1; address = a; data_in = d; byte_en = be; clear = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp);
    chip_select = 1'b1; we = 1'b0; address = a; byte_en = 4'h0; clear = 1'b0;
    exp_q.push_back(exp);
    tick();
  endtask

  task automatic idle_tick();
    set_idle();
    tick();
  endtask

  initial begin
    int cnt;
    int d20_cnt;
    reset_n = 1'b0;
    set_idle();
    address = '0;
    data_in = '0;
    #23;
    check("rst_main_busy", 32'(busy_m), 32'd1);
    check("rst_main_dout", dout_m, 32'h0);
    check("rst_main_rv", 32'(rv_m), 32'd0);
    check("rst_wt_dout", dout_w, 32'h0);
    check("rst_d20_busy", 32'(busy_d), 32'd1);

    // Clear after reset release; a read and a clear request during busy are ignored.
    @(negedge clock);
    reset_n = 1'b1;
    cnt = 0;
    d20_cnt = 0;
    do begin
      tick();
      cnt++;
      if (busy_d == 1'b0 && d20_cnt == 0) d20_cnt = cnt;
      if (cnt == 1) begin
        chip_select = 1'b1; we = 1'b0; address = 5'd0; clear = 1'b1;
      end else if (cnt == 2) begin
        set_idle();
      end
    end while (busy_m && cnt < 100);
    check("init_clear_cycles_main", 32'(cnt), 32'd32);
    check("init_clear_cycles_d20", 32'(d20_cnt), 32'd20);
    check("init_wt_busy", 32'(busy_w), 32'd0);

    rd(5'd0, 32'h0);
    rd(5'd5, 32'h0);
    rd(5'd31, 32'h0);
    idle_tick();

    // Byte-enable merge and write-through behaviour.
    wr(5'd7, 32'hDEADBEEF, 4'b1111);
    check("wt_after_wr1", dout_w, 32'hDEADBEEF);
    check("wt_rv_after_wr1", 32'(rv_w), 32'd0);
    check("main_hold_after_wr1", dout_m, 32'h0);
    wr(5'd7, 32'h11223344, 4'b0101);
    check("wt_after_wr2_merged", dout_w, 32'hDE22BE44);
    rd(5'd7, 32'hDE22BE44);
    idle_tick();
    check("main_hold_idle", dout_m, 32'hDE22BE44);

    wr(5'd3, 32'h55AA55AA, 4'hF);
    check("wt_wr3", dout_w, 32'h55AA55AA);
    check("wt_rv_wr3", 32'(rv_w), 32'd0);
    check("main_hold_wr3", dout_m, 32'hDE22BE44);
    wr(5'd8, 32'hFFFFFFFF, 4'h0);
    check("wt_be0_no_change", dout_w, 32'h0);
    set_idle();

    // Back-to-back reads.
    wr(5'd1, 32'hA, 4'hF);
    wr(5'd2, 32'hB, 4'hF);
    wr(5'd3, 32'hC, 4'hF);
    rd(5'd1, 32'hA);
    rd(5'd2, 32'hB);
    rd(5'd3, 32'hC);
    idle_tick();
    rd(5'd8, 32'h0);
    idle_tick();

    // Out-of-range on the DEPTH=20 instance; in range on the default one.
    wr(5'd25, 32'h12345678, 4'hF);
    wr(5'd19, 32'h13579BDF, 4'hF);
    rd(5'd25, 32'h12345678);
    check("d20_oor_data", dout_d, 32'h0);
    check("d20_oor_rv", 32'(rv_d), 32'd1);
    rd(5'd19, 32'h13579BDF);
    check("d20_addr19", dout_d, 32'h13579BDF);
    check("d20_addr19_rv", 32'(rv_d), 32'd1);
    idle_tick();

    // Clear has priority over a simultaneous write.
    wr(5'd4, 32'hFFFF0000, 4'hF);
    rd(5'd4, 32'hFFFF0000);
    chip_select = 1'b1; we = 1'b1; address = 5'd4; data_in = 32'h1; byte_en = 4'hF; clear = 1'b1;
    tick();
    set_idle();
    cnt = 0;
    while (busy_m && cnt < 100) begin
      cnt++;
      tick();
    end
    check("req_clear_cycles", 32'(cnt), 32'd32);
    rd(5'd4, 32'h0);
    rd(5'd7, 32'h0);
    idle_tick();

    // Reset in the middle of a clear restarts the full sequence.
    wr(5'd9, 32'hCAFEF00D, 4'hF);
    rd(5'd9, 32'hCAFEF00D);
    clear = 1'b1; chip_select = 1'b0;
    tick();
    set_idle();
    for (int i = 0; i < 5; i++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("midclr_rst_dout", dout_m, 32'h0);
    check("midclr_rst_busy", 32'(busy_m), 32'd1);
    check("midclr_rst_rv", 32'(rv_m), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (busy_m && cnt < 100);
    check("midclr_restart_cycles", 32'(cnt), 32'd32);
    rd(5'd9, 32'h0);
    idle_tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
